// File: rtl/pygmy_pkg.sv
// pygmy_pkg: shared ALU opcodes, access-size encodings, execute FSM states and load-extension helper.
package pygmy_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    localparam logic [1:0] HB_WORD = 2'b00;
    localparam logic [1:0] HB_BYTE = 2'b01;
    localparam logic [1:0] HB_HALF = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Align the addressed lane down to bit 0, then sign- or zero-extend by size.
    function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] hb, input logic ul);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        return (hb == HB_BYTE) ? {{24{~ul & s[7]}}, s[7:0]} :
               (hb == HB_HALF) ? {{16{~ul & s[15]}}, s[15:0]} : s;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU; unknown opcodes behave as ADD.
module alu
    import pygmy_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    always_comb begin
        o_result = i_a + i_b;
        case (i_op)
            OP_SUB:  o_result = i_a - i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_SLL:  o_result = i_a << i_b[4:0];
            OP_SRL:  o_result = i_a >> i_b[4:0];
            OP_SRA:  o_result = $signed(i_a) >>> i_b[4:0];
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
            default: o_result = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU plus req/gnt/rvalid load/store stage with one-cycle writeback.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module execute_stage
    import pygmy_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rd_ptr_i,
    input  logic [3:0]      alu_opcode_i,
    input  logic            alu_src_i,
    input  logic            reg_we_i,
    input  logic            mem_we_i,
    input  logic            mem_re_i,
    input  logic [1:0]      hb_i,
    input  logic            ul_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_rd_o,
    output logic [4:0]      wb_rd_ptr_o,
    output logic            wb_we_o,
`ifdef MISALIGN_TRAP_EN
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
`endif
    output logic            mem_abort_o
);

    state_t          r_state, w_next;
    logic [XLEN-1:0] w_b, w_alu, w_addr, w_wdata, w_ld_data;
    logic [3:0]      w_be;
    logic            w_accept, w_mem, w_mis, w_timeout, w_ld_done;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata, r_wb_rd;
    logic [3:0]      r_be;
    logic [4:0]      r_ptr, r_wb_ptr;
    logic [1:0]      r_hb;
    logic            r_ul, r_store, r_ld_we, r_early, r_wb_valid, r_wb_we, r_abort;
    logic [31:0]     r_cnt;
`ifdef MISALIGN_TRAP_EN
    logic            r_misalign;
    logic [XLEN-1:0] r_mis_addr;
`endif

    alu #(.XLEN(XLEN)) u_alu (
        .i_op     (alu_opcode_i),
        .i_a      (rs1_i),
        .i_b      (w_b),
        .o_result (w_alu)
    );

    assign w_b       = alu_src_i ? imm_i : rs2_i;
    assign w_addr    = rs1_i + w_b;
    assign w_accept  = issue_valid_i & issue_ready_o;
    assign w_mem     = mem_re_i | mem_we_i;
    assign w_be      = (hb_i == HB_BYTE) ? 4'b0001 << w_addr[1:0] :
                       (hb_i == HB_HALF) ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata   = (hb_i == HB_BYTE) ? {4{rs2_i[7:0]}} :
                       (hb_i == HB_HALF) ? {2{rs2_i[15:0]}} : rs2_i;
`ifdef MISALIGN_TRAP_EN
    assign w_mis     = ((hb_i == HB_HALF) & w_addr[0]) | ((hb_i[1] == hb_i[0]) & (|w_addr[1:0]));
`else
    assign w_mis     = 1'b0;
`endif
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt >= 32'(MEM_TIMEOUT - 1));
    assign w_ld_done = (r_state == WAIT) && (dmem_rvalid_i || r_early);
    // Data that arrived together with gnt was parked in r_rdata by the REQ state.
    assign w_ld_data = load_ext(r_early ? r_rdata : dmem_rdata_i, r_addr[1:0], r_hb, r_ul);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_accept && w_mem && !w_mis) ? REQ : IDLE;
            REQ:     w_next = dmem_gnt_i ? (r_store ? IDLE : WAIT) : (w_timeout ? IDLE : REQ);
            WAIT:    w_next = (w_ld_done || w_timeout) ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        issue_ready_o = (r_state == IDLE);
        dmem_req_o    = (r_state == REQ);
        dmem_we_o     = (r_state == REQ) & r_store;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_be       <= '0;
            r_ptr      <= '0;
            r_hb       <= '0;
            r_ul       <= 1'b0;
            r_store    <= 1'b0;
            r_ld_we    <= 1'b0;
            r_early    <= 1'b0;
            r_cnt      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_ptr   <= '0;
            r_abort    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
            r_mis_addr <= '0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_abort    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            if (r_state == IDLE && w_accept) begin
                if (w_mem && !w_mis) begin
                    r_addr  <= w_addr;
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_ptr   <= rd_ptr_i;
                    r_hb    <= hb_i;
                    r_ul    <= ul_i;
                    r_store <= mem_we_i;
                    r_ld_we <= reg_we_i & (rd_ptr_i != 5'd0);
                    r_early <= 1'b0;
                    r_cnt   <= '0;
                end else if (w_mem) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= '0;
                    r_wb_ptr   <= rd_ptr_i;
`ifdef MISALIGN_TRAP_EN
                    r_misalign <= 1'b1;
                    r_mis_addr <= w_addr;
`endif
                end else begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= w_alu;
                    r_wb_ptr   <= rd_ptr_i;
                    r_wb_we    <= reg_we_i & (rd_ptr_i != 5'd0);
                end
            end else if (r_state == REQ) begin
                if (dmem_gnt_i) begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_store) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= '0;
                        r_wb_ptr   <= r_ptr;
                    end else if (dmem_rvalid_i) begin
                        r_early <= 1'b1;
                        r_rdata <= dmem_rdata_i;
                    end
                end else if (w_timeout) r_abort <= 1'b1;
                else r_cnt <= r_cnt + 32'd1;
            end else if (r_state == WAIT) begin
                if (w_ld_done) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= w_ld_data;
                    r_wb_ptr   <= r_ptr;
                    r_wb_we    <= r_ld_we;
                    r_early    <= 1'b0;
                end else if (w_timeout) r_abort <= 1'b1;
                else r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_o      = r_wb_rd;
    assign wb_rd_ptr_o  = r_wb_ptr;
    assign wb_we_o      = r_wb_we;
    assign mem_abort_o  = r_abort;
`ifdef MISALIGN_TRAP_EN
    assign misalign_o      = r_misalign;
    assign misalign_addr_o = r_mis_addr;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table-driven ALU vectors plus directed memory, timeout and reset sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd_ptr;
    logic [3:0]  op;
    logic        src, reg_we, mem_we, mem_re, ul;
    logic [1:0]  hb;
    logic        req, dwe, gnt, rvalid;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        wb_valid, wb_we, abort;
    logic [31:0] wb_rd;
    logic [4:0]  wb_ptr;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] misalign_addr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .MEM_TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .rd_ptr_i(rd_ptr),
        .alu_opcode_i(op), .alu_src_i(src),
        .reg_we_i(reg_we), .mem_we_i(mem_we), .mem_re_i(mem_re),
        .hb_i(hb), .ul_i(ul),
        .dmem_req_o(req), .dmem_we_o(dwe), .dmem_addr_o(addr), .dmem_be_o(be),
        .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_rd_ptr_o(wb_ptr), .wb_we_o(wb_we),
`ifdef MISALIGN_TRAP_EN
        .misalign_o(misalign), .misalign_addr_o(misalign_addr),
`endif
        .mem_abort_o(abort)
    );

    typedef struct {
        logic [31:0] rs1, rs2, imm;
        logic [3:0]  op;
        logic        src;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] exp;
        logic        exp_we;
    } vec_t;

    vec_t v [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one memory instruction and leaves the stage one edge past acceptance.
    task automatic issue_mem(input logic st, input logic [31:0] a, input logic [31:0] off,
                             input logic [31:0] d, input logic [1:0] size, input logic u,
                             input logic [4:0] rd);
        issue_valid = 1'b1; mem_we = st; mem_re = ~st; reg_we = ~st;
        rs1 = a; imm = off; src = 1'b1; rs2 = d; hb = size; ul = u; rd_ptr = rd; op = 4'd0;
        cycle();
        issue_valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    endtask

    task automatic load_seq(input logic u, input logic [31:0] exp);
        issue_mem(1'b0, 32'h100, 32'h2, 32'h0, 2'b01, u, 5'd5);
        check("lb_req", req, 1);
        check("lb_addr", addr, 32'h102);
        check("lb_be", be, 4'b0100);
        check("lb_we", dwe, 0);
        gnt = 1'b1;
        cycle();
        gnt = 1'b0;
        check("lb_wait_req", req, 0);
        rvalid = 1'b1; rdata = 32'h0080FF00;
        cycle();
        rvalid = 1'b0; rdata = 32'h0;
        check("lb_wb_valid", wb_valid, 1);
        check("lb_wb_rd", wb_rd, exp);
        check("lb_wb_we", wb_we, 1);
        check("lb_wb_ptr", wb_ptr, 5);
        cycle();
        check("lb_wb_pulse", wb_valid, 0);
    endtask

    initial begin
        v[0]  = '{32'd5,        32'd0,        32'hFFFFFFF9, 4'd0,  1'b1, 5'd3, 1'b1, 32'hFFFFFFFE, 1'b1};
        v[1]  = '{32'h80000010, 32'd4,        32'd0,        4'd7,  1'b0, 5'd4, 1'b1, 32'hF8000001, 1'b1};
        v[2]  = '{32'h80000010, 32'd4,        32'd0,        4'd7,  1'b0, 5'd0, 1'b1, 32'hF8000001, 1'b0};
        v[3]  = '{32'd10,       32'd3,        32'd0,        4'd1,  1'b0, 5'd6, 1'b1, 32'd7,        1'b1};
        v[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        4'd2,  1'b0, 5'd7, 1'b1, 32'h0FF00FF0, 1'b1};
        v[5]  = '{32'hF0F0F0F0, 32'h0F000000, 32'd0,        4'd3,  1'b0, 5'd8, 1'b1, 32'hFFF0F0F0, 1'b1};
        v[6]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        4'd4,  1'b0, 5'd9, 1'b1, 32'hF000F000, 1'b1};
        v[7]  = '{32'd1,        32'h24,       32'd0,        4'd5,  1'b0, 5'd10, 1'b1, 32'h10,      1'b1};
        v[8]  = '{32'h80000010, 32'd4,        32'd0,        4'd6,  1'b0, 5'd11, 1'b1, 32'h08000001, 1'b1};
        v[9]  = '{32'hFFFFFFFF, 32'd1,        32'd0,        4'd8,  1'b0, 5'd12, 1'b1, 32'd1,       1'b1};
        v[10] = '{32'hFFFFFFFF, 32'd1,        32'd0,        4'd9,  1'b0, 5'd13, 1'b1, 32'd0,       1'b1};
        v[11] = '{32'h20,       32'd0,        32'h10,       4'd15, 1'b1, 5'd14, 1'b1, 32'h30,      1'b1};
        v[12] = '{32'h20,       32'd0,        32'h10,       4'd0,  1'b1, 5'd15, 1'b0, 32'h30,      1'b0};

        rst_n = 1'b0; issue_valid = 1'b0; rs1 = '0; rs2 = '0; imm = '0; rd_ptr = '0; op = '0;
        src = 1'b0; reg_we = 1'b0; mem_we = 1'b0; mem_re = 1'b0; hb = '0; ul = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_dwe", dwe, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_abort", abort, 0);
        check("rst_ready", issue_ready, 1);
        check("rst_addr", addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            issue_valid = 1'b1; rs1 = v[i].rs1; rs2 = v[i].rs2; imm = v[i].imm; op = v[i].op;
            src = v[i].src; rd_ptr = v[i].rd; reg_we = v[i].we;
            cycle();
            issue_valid = 1'b0;
            check($sformatf("alu%0d_valid", i), wb_valid, 1);
            check($sformatf("alu%0d_rd", i), wb_rd, v[i].exp);
            check($sformatf("alu%0d_we", i), wb_we, v[i].exp_we);
            check($sformatf("alu%0d_ptr", i), wb_ptr, v[i].rd);
            check($sformatf("alu%0d_ready", i), issue_ready, 1);
            check($sformatf("alu%0d_req", i), req, 0);
        end
        cycle();
        check("alu_wb_pulse", wb_valid, 0);

        load_seq(1'b0, 32'hFFFFFF80);
        load_seq(1'b1, 32'h00000080);

        issue_mem(1'b1, 32'h200, 32'h6, 32'h1234ABCD, 2'b10, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            check("sh_req", req, 1);
            check("sh_dwe", dwe, 1);
            check("sh_addr", addr, 32'h206);
            check("sh_be", be, 4'b1100);
            check("sh_wdata", wdata, 32'hABCDABCD);
            check("sh_ready", issue_ready, 0);
            check("sh_no_wb", wb_valid, 0);
            cycle();
        end
        check("sh_req_hold", req, 1);
        gnt = 1'b1;
        cycle();
        gnt = 1'b0;
        check("sh_wb_valid", wb_valid, 1);
        check("sh_wb_we", wb_we, 0);
        check("sh_req_drop", req, 0);
        check("sh_ready_back", issue_ready, 1);

        issue_mem(1'b0, 32'h100, 32'h0, 32'h0, 2'b00, 1'b0, 5'd7);
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF;
        cycle();
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        check("zw_no_wb_yet", wb_valid, 0);
        check("zw_waiting", issue_ready, 0);
        cycle();
        check("zw_wb_valid", wb_valid, 1);
        check("zw_wb_rd", wb_rd, 32'hDEADBEEF);
        check("zw_ready", issue_ready, 1);

        begin
            int k = 0;
            logic seen = 1'b0;
            issue_mem(1'b0, 32'h300, 32'h0, 32'h0, 2'b00, 1'b0, 5'd9);
            gnt = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                cycle();
                gnt = 1'b0;
                if (wb_valid) seen = 1'b1;
                if (abort) begin
                    k = i;
                    break;
                end
            end
            check("to_cycles", k, 8);
            check("to_no_wb", seen, 0);
            check("to_ready", issue_ready, 1);
            cycle();
            check("to_pulse", abort, 0);
        end

        issue_mem(1'b0, 32'h3, 32'h0, 32'h0, 2'b00, 1'b0, 5'd4);
`ifdef MISALIGN_TRAP_EN
        check("mis_no_req", req, 0);
        check("mis_pulse", misalign, 1);
        check("mis_addr", misalign_addr, 32'h3);
        check("mis_wb_valid", wb_valid, 1);
        check("mis_wb_we", wb_we, 0);
        cycle();
        check("mis_pulse_end", misalign, 0);
        check("mis_addr_hold", misalign_addr, 32'h3);
`else
        check("mis_req", req, 1);
        check("mis_addr", addr, 32'h3);
        check("mis_be", be, 4'b1111);
        gnt = 1'b1;
        cycle();
        gnt = 1'b0; rvalid = 1'b1;
        cycle();
        rvalid = 1'b0;
        check("mis_done", issue_ready, 1);
`endif

        issue_mem(1'b0, 32'h400, 32'h0, 32'h0, 2'b00, 1'b0, 5'd2);
        check("rreq_req", req, 1);
        #2 rst_n = 1'b0;
        #1 check("rreq_async_drop", req, 0);
        check("rreq_ready", issue_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue_mem(1'b0, 32'h400, 32'h0, 32'h0, 2'b00, 1'b0, 5'd2);
        gnt = 1'b1;
        cycle();
        gnt = 1'b0;
        check("rwait_in_wait", issue_ready, 0);
        #2 rst_n = 1'b0;
        #1 check("rwait_req", req, 0);
        check("rwait_idle", issue_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'h12345678;
        cycle();
        rvalid = 1'b0;
        check("rwait_no_wb", wb_valid, 0);
        check("rwait_ready", issue_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
